// File: rtl/screen_scanner_pkg.sv
// Shared constants and FSM encoding for the screen scanner.
// Screen geometry defaults describe the 512x256 monochrome display.
package screen_scanner_pkg;

  localparam int SCAN_WORDS_PER_LINE = 32;
  localparam int SCAN_LINES          = 256;
  localparam int FRAME_WORDS         = 8192;
  localparam int SCREEN_BASE         = 16384;
  localparam int ADDR_W              = 13;
  localparam int WORD_W              = 16;
  localparam int BIT_W               = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SHIFT = 2'd2
  } scan_state_e;

endpackage

// File: rtl/screen_scanner_pixel_shifter.sv
// Holds one screen word and walks a bit index across it, leftmost pixel first.
// Load wins over advance; a load always restarts at bit 0.
module pixel_shifter
  import screen_scanner_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              advance,
  input  logic [WORD_W-1:0] load_data,
  output logic              pixel,
  output logic              last_bit,
  output logic [BIT_W-1:0]  bit_idx
);

  logic [WORD_W-1:0] shreg;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (load) begin
      shreg   <= load_data;
      bit_idx <= '0;
    end else if (advance) begin
      bit_idx <= bit_idx + 1'b1;
    end
  end

  assign pixel    = shreg[bit_idx];
  assign last_bit = &bit_idx;

endmodule

// File: rtl/screen_scanner.sv
// Streams a frame of screen RAM out as a valid/ready pixel stream.
// Handshake: a pixel transfers on a posedge where pix_valid & pix_ready; while stalled, pixel/sof/eol hold.
module screen_scanner
  import screen_scanner_pkg::*;
#(
  parameter int WORDS_PER_LINE = SCAN_WORDS_PER_LINE,
  parameter int LINES          = SCAN_LINES
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [WORD_W-1:0] mem_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pixel,
  output logic              sof,
  output logic              eol,
  output logic              frame_done,
  output scan_state_e       state_dbg
);

  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(WORDS_PER_LINE * LINES - 1);

  scan_state_e       state, next_state;
  logic [ADDR_W-1:0] word_cnt;
  logic [ADDR_W-1:0] cur_word;
  logic              frame_done_q;
  logic              load, advance;
  logic              sh_pixel, last_bit;
  logic [BIT_W-1:0]  bit_idx;
  logic              transfer, frame_end;

  assign transfer  = (state == ST_SHIFT) & pix_ready;
  assign frame_end = transfer & last_bit & (cur_word == LAST_WORD);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (enable) next_state = ST_FETCH;
      ST_FETCH: next_state = ST_SHIFT;
      ST_SHIFT: if (frame_end && !enable) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  // When a frame ends without enable, skip the reload so the counter rests at 0.
  always_comb begin
    pix_valid = 1'b0;
    load      = 1'b0;
    advance   = 1'b0;
    case (state)
      ST_FETCH: load = 1'b1;
      ST_SHIFT: begin
        pix_valid = 1'b1;
        if (transfer) begin
          if (last_bit) load = !(frame_end && !enable);
          else          advance = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // word_cnt always points at the next word to load, so mem_data is ready at the word boundary.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      word_cnt     <= '0;
      cur_word     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_end;
      if (load) begin
        cur_word <= word_cnt;
        word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
      end
    end
  end

  pixel_shifter u_shifter (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .advance   (advance),
    .load_data (mem_data),
    .pixel     (sh_pixel),
    .last_bit  (last_bit),
    .bit_idx   (bit_idx)
  );

  assign mem_addr   = word_cnt;
  assign pixel      = pix_valid & sh_pixel;
  assign sof        = pix_valid & (cur_word == '0) & (bit_idx == '0);
  assign eol        = pix_valid & last_bit &
                      ((32'(cur_word) % WORDS_PER_LINE) == WORDS_PER_LINE - 1);
  assign frame_done = frame_done_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_screen_scanner.sv
// Directed bench for screen_scanner using a reduced 32x4-word frame (2048 pixels).
// A cycle model tracks the expected pixel position; each task compares outputs inline.
module tb_screen_scanner;
  import screen_scanner_pkg::*;

  localparam int WPL       = 32;
  localparam int NLINES    = 4;
  localparam int FRAME_W   = WPL * NLINES;
  localparam int FRAME_PIX = FRAME_W * 16;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [12:0] mem_addr;
  logic [15:0] mem_data;
  logic        pix_valid;
  logic        pix_ready;
  logic        pixel;
  logic        sof;
  logic        eol;
  logic        frame_done;
  scan_state_e state_dbg;

  logic [15:0] ram [0:8191];
  assign mem_data = ram[mem_addr];

  screen_scanner #(.WORDS_PER_LINE(WPL), .LINES(NLINES)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pixel      (pixel),
    .sof        (sof),
    .eol        (eol),
    .frame_done (frame_done),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  int          vectors;
  int          miscompares;
  int          p;
  int          m_frames;
  scan_state_e m_st;
  logic        m_fd;
  logic        m_rst;

  function automatic logic [19:0] obs_vec();
    return {pix_valid, pixel, sof, eol, frame_done, mem_addr, 2'(state_dbg)};
  endfunction

  function automatic logic [19:0] exp_vec();
    logic        v, px, so, eo;
    logic [15:0] w;
    logic [12:0] a;
    int          wi;
    v  = (m_st == ST_SHIFT);
    wi = p / 16;
    w  = ram[wi];
    px = v & w[p % 16];
    so = v & (p == 0);
    eo = v & ((p % 16) == 15) & ((wi % WPL) == WPL - 1);
    a  = v ? 13'((wi + 1) % FRAME_W) : 13'd0;
    return {v, px, so, eo, m_fd, a, 2'(m_st)};
  endfunction

  // pixel/sof/eol only matter while valid, or right after reset where they must be 0
  function automatic logic [19:0] care();
    return (m_st == ST_SHIFT || m_rst) ? 20'hFFFFF : 20'h8FFFF;
  endfunction

  // driver: advance the model by the inputs now applied, then wait for the sample point
  task automatic tick();
    m_fd  = 1'b0;
    m_rst = !reset_n;
    if (!reset_n) begin
      m_st = ST_IDLE;
      p    = 0;
    end else begin
      case (m_st)
        ST_IDLE:  if (enable) m_st = ST_FETCH;
        ST_FETCH: begin m_st = ST_SHIFT; p = 0; end
        default: if (pix_ready) begin
          if (p == FRAME_PIX - 1) begin
            m_fd = 1'b1;
            m_frames++;
            p = 0;
            if (!enable) m_st = ST_IDLE;
          end else begin
            p++;
          end
        end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL reset cyc=%0d got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_first_word();
    reset_n = 1'b1; enable = 1'b1; pix_ready = 1'b1;
    for (int i = 0; i < 18; i++) begin
      tick();
      vectors++;
      if ((obs_vec() & care()) !== (exp_vec() & care())) begin
        miscompares++;
        $display("FAIL first_word cyc=%0d got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (i == 1) begin
        vectors++;
        if ({pix_valid, pixel, sof} !== 3'b111) begin
          miscompares++;
          $display("FAIL first_pixel got valid/pixel/sof=%b expected 111", {pix_valid, pixel, sof});
        end
      end
    end
  endtask

  task automatic test_line_boundary();
    enable = 1'b1; pix_ready = 1'b1;
    for (int i = 0; i < 600 && p < 32 * 16 + 4; i++) begin
      tick();
      vectors++;
      if ((obs_vec() & care()) !== (exp_vec() & care())) begin
        miscompares++;
        $display("FAIL line_boundary p=%0d got %h expected %h", p, obs_vec(), exp_vec());
      end
      if (p == 31 * 16 + 15) begin
        vectors++;
        if ({eol, pixel} !== 2'b11) begin
          miscompares++;
          $display("FAIL eol_word31 got eol/pixel=%b expected 11", {eol, pixel});
        end
      end
    end
    vectors++;
    if (p != 32 * 16 + 4) begin
      miscompares++;
      $display("FAIL line_boundary timeout p=%0d expected %0d", p, 32 * 16 + 4);
    end
  endtask

  task automatic test_stall();
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      pix_ready = 1'($urandom_range(0, 1));
      tick();
      vectors++;
      if ((obs_vec() & care()) !== (exp_vec() & care())) begin
        miscompares++;
        $display("FAIL stall p=%0d got %h expected %h", p, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    int start_frames;
    int fd_seen;
    start_frames = m_frames;
    fd_seen = 0;
    enable = 1'b1; pix_ready = 1'b1;
    for (int i = 0; i < 6000 && m_frames < start_frames + 2; i++) begin
      tick();
      if (frame_done === 1'b1) fd_seen++;
      vectors++;
      if ((obs_vec() & care()) !== (exp_vec() & care())) begin
        miscompares++;
        $display("FAIL back_to_back p=%0d got %h expected %h", p, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if (fd_seen != 2 || m_frames != start_frames + 2) begin
      miscompares++;
      $display("FAIL frame_done_count got %0d expected 2", fd_seen);
    end
  endtask

  task automatic test_enable_drop();
    enable = 1'b1; pix_ready = 1'b1;
    for (int i = 0; i < 3000 && p != 1000; i++) begin
      tick();
      vectors++;
      if ((obs_vec() & care()) !== (exp_vec() & care())) begin
        miscompares++;
        $display("FAIL enable_drop_run p=%0d got %h expected %h", p, obs_vec(), exp_vec());
      end
    end
    enable = 1'b0;
    for (int i = 0; i < 3000 && m_st != ST_IDLE; i++) begin
      tick();
      vectors++;
      if ((obs_vec() & care()) !== (exp_vec() & care())) begin
        miscompares++;
        $display("FAIL enable_drop_drain p=%0d got %h expected %h", p, obs_vec(), exp_vec());
      end
    end
    tick();
    tick();
    vectors++;
    if ({pix_valid, state_dbg, mem_addr} !== {1'b0, ST_IDLE, 13'd0}) begin
      miscompares++;
      $display("FAIL enable_drop_idle got valid=%b state=%0d addr=%0d expected 0/0/0",
               pix_valid, state_dbg, mem_addr);
    end
  endtask

  task automatic test_reset_mid_frame();
    enable = 1'b1; pix_ready = 1'b1;
    for (int i = 0; i < 4000 && !(m_st == ST_SHIFT && p == 100 * 16); i++) begin
      tick();
      vectors++;
      if ((obs_vec() & care()) !== (exp_vec() & care())) begin
        miscompares++;
        $display("FAIL reset_mid_run p=%0d got %h expected %h", p, obs_vec(), exp_vec());
      end
    end
    reset_n = 1'b0;
    tick();
    vectors++;
    if (obs_vec() !== 20'h0) begin
      miscompares++;
      $display("FAIL reset_mid_abort got %h expected 00000", obs_vec());
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ((obs_vec() & care()) !== (exp_vec() & care())) begin
        miscompares++;
        $display("FAIL reset_mid_restart cyc=%0d got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (i == 1) begin
        vectors++;
        if ({pix_valid, sof, mem_addr} !== {2'b11, 13'd1}) begin
          miscompares++;
          $display("FAIL restart_sof got valid=%b sof=%b addr=%0d expected 1/1/1",
                   pix_valid, sof, mem_addr);
        end
      end
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    p = 0; m_frames = 0; m_st = ST_IDLE; m_fd = 1'b0; m_rst = 1'b1;
    reset_n = 1'b0; enable = 1'b0; pix_ready = 1'b0;
    for (int w = 0; w < 8192; w++) ram[w] = 16'(w * 40503) ^ 16'h5a5a;
    ram[0]  = 16'h0001;
    ram[31] = 16'h8000;

    test_reset();
    test_first_word();
    test_line_boundary();
    test_stall();
    test_back_to_back();
    test_enable_drop();
    test_reset_mid_frame();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/screen_scanner.md
SCREEN_SCANNER -- requirements
Module: screen_scanner

Interface
REQ-001 Parameter WORDS_PER_LINE, default 32, meaning 16-bit screen words per scan line (512 pixels).
REQ-002 Parameter LINES, default 256, meaning scan lines per frame; frame size = WORDS_PER_LINE*LINES = 8192 words.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset_n  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 enable  input  1  level request to scan frames continuously.
REQ-006 mem_addr  output  13  word address into screen RAM8K (asynchronous read).
REQ-007 mem_data  input  16  RAM8K read data for mem_addr, valid in the same cycle.
REQ-008 pix_valid  output  1  pixel output holds a valid pixel.
REQ-009 pix_ready  input  1  display sink accepts the pixel this cycle.
REQ-010 pixel  output  1  current pixel, 1 = black.
REQ-011 sof  output  1  current pixel is frame pixel (0,0); qualified by pix_valid.
REQ-012 eol  output  1  current pixel is the last pixel of a line; qualified by pix_valid.
REQ-013 frame_done  output  1  one-cycle pulse after the last pixel of a frame transfers.

Function
REQ-014 States IDLE, FETCH, SHIFT; transfer = pix_valid & pix_ready.
REQ-015 IDLE: pix_valid=0, mem_addr=0; enable=1 -> FETCH next cycle.
REQ-016 FETCH (one cycle): load shift register from mem_data at address 0, bit index 0, word counter advances to 1; -> SHIFT. First pix_valid appears 2 cycles after enable sampled high.
REQ-017 SHIFT: pix_valid=1; pixel = shift register bit[bit index]; bit 0 is leftmost pixel.
REQ-018 pixel, sof, eol SHALL hold stable while pix_valid=1 and pix_ready=0.
REQ-019 Transfer with bit index < 15: bit index increments.
REQ-020 Transfer with bit index = 15: shift register loads mem_data (mem_addr = next word already), bit index -> 0, word counter increments mod 8192; no bubble cycle between words.
REQ-021 mem_addr SHALL always equal the word counter register (address of the next word to load).
REQ-022 sof = 1 when current word = 0 and bit index = 0.
REQ-023 eol = 1 when bit index = 15 and current word mod WORDS_PER_LINE = WORDS_PER_LINE-1.
REQ-024 Transfer of word 8191 bit 15: frame_done=1 next cycle; enable=1 -> continue seamlessly with word 0 (wrap); enable=0 -> IDLE, pix_valid=0 next cycle.
REQ-025 enable deasserted mid-frame SHALL be ignored until frame end (frames always complete).
REQ-026 RAM contents changed during a frame: scanner shows the value present at the load edge; no coherency guarantee.
REQ-027 Counter arithmetic unsigned, 13-bit word counter, 4-bit bit index, wrap without overflow flags.

Reset
REQ-028 reset_n=0 at posedge: state IDLE, word counter 0, bit index 0, shift register 0.
REQ-029 During/after reset: pix_valid=0, pixel=0, sof=0, eol=0, frame_done=0, mem_addr=0.
REQ-030 Reset mid-frame SHALL abort immediately; next enable restarts at pixel (0,0).

Structure
REQ-031 Shared constants file holds WORDS_PER_LINE, LINES, FRAME_WORDS=8192, SCREEN_BASE=16384 and state encodings.
REQ-032 One sub-module pixel_shifter: 16-bit load register plus 4-bit bit index, load/advance controls, pixel and last-bit outputs.
REQ-033 Top holds FSM, word counter, sof/eol/frame_done decode.

Verification
REQ-034 Reset, enable=1, pix_ready=1, word0=16'h0001 -> pix_valid at cycle 2, first pixel=1, sof=1, next 15 pixels=0.
REQ-035 word31=16'h8000, pix_ready=1 -> eol=1 exactly on word31 bit15, pixel=1; next pixel from word32 with no bubble.
REQ-036 pix_ready toggled 1/0 randomly -> pixel/sof/eol stable while stalled; 131072 transfers per frame, none lost/duplicated.
REQ-037 enable=1 throughout -> frame_done pulses once per 131072 transfers; mem_addr wraps 8191->0; sof reappears.
REQ-038 enable dropped at transfer 1000 -> frame still completes, then pix_valid=0, state IDLE.
REQ-039 reset_n=0 mid-frame at word 500 -> outputs 0 next cycle; re-enable restarts at mem_addr 0 with sof=1.
